spi_lcd_rx: RTL
===============

// Module: spi_lcd_rx
// PURPOSE
//  Display-side receiver for the 4-wire SPI LCD stream (MOSI/DC/CS/SCLK) our drawing engines emit.
//  Deserialises bytes, decodes SET_COLUMN (0x2A), SET_PAGE (0x2B) and WRITE_RAM (0x2C), and tracks the address window.
//  Emits one (x, y, RGB565) pixel strobe per received pixel, for a framebuffer model or an on-chip mirror/checker.
//  Sits after the SPI pins (loopback) or in the testbench as the golden panel model.
// PARAMETERS
//  WIDTH       240    columns; valid x range 0..WIDTH-1
//  HEIGHT      320    rows; valid y range 0..HEIGHT-1
// PORTS
//  i_clk        in   1   system clock; must be >= 4x SCLK frequency
//  i_rst_n      in   1   asynchronous, active-low reset
//  i_sclk       in   1   SPI clock from the transmitter (async to i_clk); idles low, data sampled on rising edge
//  i_mosi       in   1   serial data, MSB first
//  i_dc         in   1   0 = command byte, 1 = data byte
//  i_cs         in   1   chip select, active low
//  o_cmd_valid  out  1   1-cycle pulse: a command byte completed
//  o_cmd        out  8   last command byte; held until the next command
//  o_px_valid   out  1   1-cycle pulse: a pixel completed
//  o_px_x       out  9   pixel column, valid with o_px_valid
//  o_px_y       out  9   pixel row, valid with o_px_valid
//  o_px_data    out  16  RGB565 pixel, first byte = [15:8]
//  o_err        out  1   sticky: an invalid window was received; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0; SC=0, EC=WIDTH-1, SP=0, EP=HEIGHT-1; x=0, y=0; bit count 0; state IDLE.
//  Input sync: i_sclk, i_mosi, i_dc and i_cs each pass through 2 flops; SCLK rising edge detected on the synced copy.
//  Bit capture: on each detected edge with synced CS low, shift MOSI into bit[0]; after the 8th bit, form the byte and sample DC.
//  CS high (synced) clears bit count; a partial byte is discarded silently and the decode state is kept.
//  Byte strobe: outputs change on the 1st i_clk cycle after the edge that completed the byte.
//  FSM states: IDLE, COL_P (param idx 0..3), PAGE_P (0..3), RAM, IGNORE.
//   DC=0 byte (any state): o_cmd<=byte, o_cmd_valid=1, param idx<=0, pending pixel byte dropped.
//     0x2A->COL_P, 0x2B->PAGE_P, 0x2C->RAM with x<=SC, y<=SP, other->IGNORE.
//   COL_P: params 0..3 = SC[15:8], SC[7:0], EC[15:8], EC[7:0]. On the 4th param, commit only if SC<=EC and EC<WIDTH;
//     otherwise set o_err and keep the old window. Then ->IDLE.
//   PAGE_P: same as COL_P using SP/EP and HEIGHT.
//   RAM: even data byte latched as high byte; odd data byte completes the pixel.
//     o_px_valid=1, o_px_x=x, o_px_y=y, o_px_data={hi,lo}.
//     Then if x==EC: x<=SC and y<=(y==EP ? SP : y+1); else x<=x+1.
//     Wrap is silent: no error, no stall.
//   IGNORE, IDLE: data bytes consumed with no effect. In COL_P/PAGE_P, data beyond the 4th param is ignored.
//  Parameter bytes are assembled in 16 bits, compared at 16 bits, and stored as 9 bits.
//  Params in progress are not committed if a new command arrives first.
//  Pixel strobes use the window values committed at the time 0x2C arrived.
//  o_cmd_valid and o_px_valid are never high in the same cycle; at most one byte completes per 4 i_clk.
//  Reset mid-stream: everything returns to reset values immediately, including the window; in-flight bits are lost.
// TESTING
//  Row-band clear: 2A 00 00 00 EF, 2B 00 00 00 07, 2C, then 3840 x 00.
//    -> 1920 px strobes, all data 0x0000; first (0,0), 240th (239,0), last (239,7).
//    -> 3 cmd pulses with o_cmd 2A, 2B, 2C.
//  Window wrap: 2A 00 0A 00 0B, 2B 00 14 00 15, 2C, 10 bytes F8 00.
//    -> 5 px at (10,20), (11,20), (10,21), (11,21), (10,20), each 0xF800.
//  CS abort: CS low, 5 bits of 0x2A, CS high, CS low, full 0x2B.
//    -> exactly one cmd pulse, o_cmd=0x2B, no 0x2A seen.
//  Bad window: 2A 00 F0 00 F0 (EC=240) -> o_err=1, window stays 0..239.
//    Then 2C + 2 bytes -> px at (0,0).
//  Unknown command and split pixel: 2C, byte 12, cmd 0x36, byte 34.
//    -> no pixel; o_cmd=0x36; byte 34 ignored.
//  Reset mid-pixel: drop i_rst_n after 1 pixel byte plus 3 bits.
//    -> outputs 0 and window restored; next 2C 12 34 gives px (0,0)=0x1234.

Source files
------------

// File: rtl/spi_lcd_rx_if.sv
// SPI LCD receiver bus: the four serial input pins plus the decoded
// command and pixel strobes coming back out of the receiver.
interface spi_lcd_rx_if;
    logic        i_sclk;
    logic        i_mosi;
    logic        i_dc;
    logic        i_cs;
    logic        o_cmd_valid;
    logic [7:0]  o_cmd;
    logic        o_px_valid;
    logic [8:0]  o_px_x;
    logic [8:0]  o_px_y;
    logic [15:0] o_px_data;
    logic        o_err;

    // Transmitter / testbench side.
    modport master (
        output i_sclk, i_mosi, i_dc, i_cs,
        input  o_cmd_valid, o_cmd, o_px_valid, o_px_x, o_px_y, o_px_data, o_err
    );

    // Receiver side.
    modport slave (
        input  i_sclk, i_mosi, i_dc, i_cs,
        output o_cmd_valid, o_cmd, o_px_valid, o_px_x, o_px_y, o_px_data, o_err
    );
endinterface

// File: rtl/spi_lcd_rx.sv
// Display-side receiver for the 4-wire SPI LCD stream. Oversamples SCLK with
// i_clk, deserialises bytes, decodes column/page window and RAM-write commands
// and emits one (x, y, RGB565) strobe per received pixel.
module spi_lcd_rx #(
    parameter int unsigned WIDTH  = 240,
    parameter int unsigned HEIGHT = 320
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    spi_lcd_rx_if.slave  bus
);

    localparam logic [15:0] WidthLim  = 16'(WIDTH);
    localparam logic [15:0] HeightLim = 16'(HEIGHT);
    localparam logic [8:0]  EcInit    = 9'(WIDTH - 1);
    localparam logic [8:0]  EpInit    = 9'(HEIGHT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StColP,
        StPageP,
        StRam,
        StIgnore
    } state_t;

    logic [1:0]  sclk_sync, mosi_sync, dc_sync, cs_sync;
    logic        sclk_prev;
    logic        sclk_rise;
    logic        cs_act;

    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic        byte_stb;
    logic [7:0]  byte_val;
    logic        byte_dc;

    state_t      state;
    logic [1:0]  par_idx;
    logic [7:0]  par_hi;
    logic [15:0] par_start;
    logic [15:0] par_end;
    logic [8:0]  sc, ec, sp, ep;
    logic [8:0]  x, y;
    logic [7:0]  px_hi;
    logic        px_half;

    // Two-flop synchronisers for all SPI pins plus a delayed SCLK for edge detect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            dc_sync   <= 2'b00;
            cs_sync   <= 2'b11;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], bus.i_sclk};
            mosi_sync <= {mosi_sync[0], bus.i_mosi};
            dc_sync   <= {dc_sync[0], bus.i_dc};
            cs_sync   <= {cs_sync[0], bus.i_cs};
            sclk_prev <= sclk_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign cs_act    = ~cs_sync[1];
    assign byte_stb  = cs_act & sclk_rise & (bit_cnt == 3'd7);
    assign byte_val  = {shift[6:0], mosi_sync[1]};
    assign byte_dc   = dc_sync[1];
    assign par_end   = {par_hi, byte_val};

    // Bit deserialiser; deasserted CS throws away any partial byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift   <= 8'h00;
            bit_cnt <= 3'd0;
        end else if (!cs_act) begin
            bit_cnt <= 3'd0;
        end else if (sclk_rise) begin
            shift   <= byte_val;
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Command decode, window tracking and pixel assembly, with registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= StIdle;
            par_idx         <= 2'd0;
            par_hi          <= 8'h00;
            par_start       <= 16'h0000;
            sc              <= 9'd0;
            ec              <= EcInit;
            sp              <= 9'd0;
            ep              <= EpInit;
            x               <= 9'd0;
            y               <= 9'd0;
            px_hi           <= 8'h00;
            px_half         <= 1'b0;
            bus.o_cmd_valid <= 1'b0;
            bus.o_cmd       <= 8'h00;
            bus.o_px_valid  <= 1'b0;
            bus.o_px_x      <= 9'd0;
            bus.o_px_y      <= 9'd0;
            bus.o_px_data   <= 16'h0000;
            bus.o_err       <= 1'b0;
        end else begin
            bus.o_cmd_valid <= 1'b0;
            bus.o_px_valid  <= 1'b0;
            if (byte_stb) begin
                if (!byte_dc) begin
                    bus.o_cmd       <= byte_val;
                    bus.o_cmd_valid <= 1'b1;
                    par_idx         <= 2'd0;
                    px_half         <= 1'b0;
                    case (byte_val)
                        8'h2A:   state <= StColP;
                        8'h2B:   state <= StPageP;
                        8'h2C: begin
                            state <= StRam;
                            x     <= sc;
                            y     <= sp;
                        end
                        default: state <= StIgnore;
                    endcase
                end else begin
                    case (state)
                        StColP, StPageP: begin
                            par_idx <= par_idx + 2'd1;
                            unique case (par_idx)
                                2'd0: par_hi    <= byte_val;
                                2'd1: par_start <= par_end;
                                2'd2: par_hi    <= byte_val;
                                2'd3: begin
                                    // Full 16-bit check so oversized values cannot alias into range.
                                    if (state == StColP) begin
                                        if (par_start <= par_end && par_end < WidthLim) begin
                                            sc <= par_start[8:0];
                                            ec <= par_end[8:0];
                                        end else begin
                                            bus.o_err <= 1'b1;
                                        end
                                    end else begin
                                        if (par_start <= par_end && par_end < HeightLim) begin
                                            sp <= par_start[8:0];
                                            ep <= par_end[8:0];
                                        end else begin
                                            bus.o_err <= 1'b1;
                                        end
                                    end
                                    state <= StIdle;
                                end
                            endcase
                        end
                        StRam: begin
                            if (!px_half) begin
                                px_hi   <= byte_val;
                                px_half <= 1'b1;
                            end else begin
                                px_half        <= 1'b0;
                                bus.o_px_valid <= 1'b1;
                                bus.o_px_x     <= x;
                                bus.o_px_y     <= y;
                                bus.o_px_data  <= {px_hi, byte_val};
                                if (x == ec) begin
                                    x <= sc;
                                    y <= (y == ep) ? sp : y + 9'd1;
                                end else begin
                                    x <= x + 9'd1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
